hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// Pipeline hazard sequencer for the 5-stage ARM core; sits beside the forwarding unit.
// Detects RAW hazards between ID sources and in-flight EX/MEM destinations and emits stall/bubble.
// Flushes on taken branch and freezes the whole pipe while the data-memory port waits.
// Also supplies the registered forwarding enable (fw_en_q) consumed by the forwarding unit.
// PARAMETERS
// CNT_W        16   width of each saturating performance counter
// TIMEOUT      255  max MEM_WAIT cycles before mem_err is raised (>=1)
// TO_W         8    width of the wait-cycle counter; must hold TIMEOUT
// PORTS
// clk          in   1     core clock, all state on rising edge
// rst          in   1     asynchronous, active-low reset
// FW_EN        in   1     requested forwarding mode (1 = forwarding on)
// id_valid     in   1     ID stage holds a real instruction
// src1, src2   in   4     ID source register numbers
// two_src      in   1     ID instruction reads src2
// EX_Dest      in   4     EX stage destination
// EX_WB_EN     in   1     EX stage writes back
// EX_MEM_R_EN  in   1     EX stage is a load
// MEM_Dest     in   4     MEM stage destination
// MEM_WB_EN    in   1     MEM stage writes back
// mem_req      in   1     MEM stage is accessing data memory
// mem_ready    in   1     data memory access completes this cycle
// branch_taken in   1     EX resolves a taken branch
// fw_en_q      out  1     registered forwarding enable
// hazard_stall out  1     hold PC and IF/ID
// id_ex_bubble out  1     load NOP into ID/EX
// flush        out  1     clear IF/ID and ID/EX
// freeze       out  1     hold every pipeline register
// mem_err      out  1     sticky memory timeout flag
// stall_cnt, flush_cnt, freeze_cnt  out  CNT_W  saturating event counters
// BEHAVIOUR
// Reset: state=RUN, fw_en_q=0, mem_err=0, all counters=0, wait counter=0; comb outputs follow.
// hz1 = id_valid & EX_WB_EN & src1==EX_Dest; hz2 = id_valid & two_src & EX_WB_EN & src2==EX_Dest.
// hm1/hm2 same against MEM_Dest/MEM_WB_EN.
// fw_en_q=1: raw = (hz1|hz2) & EX_MEM_R_EN (load-use only). fw_en_q=0: raw = hz1|hz2|hm1|hm2.
// FSM states RUN, MEM_WAIT (2 states, encoding in package).
// RUN: freeze = mem_req & ~mem_ready; if set -> MEM_WAIT next, wait counter loads 1.
// MEM_WAIT: freeze=1 until mem_ready=1 (same-cycle release, freeze=0), then -> RUN.
//  Wait counter increments per cycle; reaching TIMEOUT sets mem_err, forces -> RUN.
// Priority per cycle: freeze > flush > raw. flush = branch_taken & ~freeze.
// hazard_stall = id_ex_bubble = raw & ~freeze & ~flush (combinational, zero latency).
// fw_en_q <= FW_EN only in a quiescent cycle: state RUN, ~freeze, ~flush, ~raw; else holds.
// Counters increment by 1 on cycles with hazard_stall / flush / freeze; saturate at all-ones.
// mem_err cleared only by reset.
// rst asserted mid-MEM_WAIT: immediate return to reset values; freeze drops asynchronously.
// Register 0 has no special meaning; src==Dest matches include r0.
// STRUCTURE
// Package hazard_pkg: state enum (RUN, MEM_WAIT), REG_W=4 constant.
// One sub-module: sat_counter (CNT_W, inc -> count), instantiated three times.
// All hazard compare logic and FSM inline in hazard_controller.
// TESTING
// fw_en_q=1, EX load to r3, ID src1=r3 -> stall=bubble=1 one cycle; EX_MEM_R_EN=0 -> stall=0.
// fw_en_q=0, MEM_Dest=r5 MEM_WB_EN=1, src2=r5 two_src=1 -> stall=1; two_src=0 -> stall=0.
// mem_req=1, mem_ready low 3 cycles -> freeze=1 for 3 cycles, freeze_cnt=3, back to RUN.
// mem_ready never, TIMEOUT=4 -> mem_err=1 after 4 wait cycles, FSM in RUN, mem_err stays.
// branch_taken with simultaneous load-use -> flush=1, stall=0; with freeze -> flush=0.
// FW_EN toggled during stall -> fw_en_q unchanged until first quiescent cycle, then updates.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_pkg;

  localparam int REG_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // A writer only hazards a reader when it actually writes back; r0 is an ordinary register.
  function automatic logic reg_match(input logic wb_en,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dest);
    return wb_en & (src == dest);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline-side signals seen by the hazard sequencer
interface hazard_controller_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) ();
  logic             FW_EN;
  logic             id_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             two_src;
  logic [REG_W-1:0] EX_Dest;
  logic             EX_WB_EN;
  logic             EX_MEM_R_EN;
  logic [REG_W-1:0] MEM_Dest;
  logic             MEM_WB_EN;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;
  logic             fw_en_q;
  logic             hazard_stall;
  logic             id_ex_bubble;
  logic             flush;
  logic             freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output FW_EN, id_valid, src1, src2, two_src, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
           MEM_Dest, MEM_WB_EN, mem_req, mem_ready, branch_taken,
    input  fw_en_q, hazard_stall, id_ex_bubble, flush, freeze, mem_err,
           stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  FW_EN, id_valid, src1, src2, two_src, EX_Dest, EX_WB_EN, EX_MEM_R_EN,
           MEM_Dest, MEM_WB_EN, mem_req, mem_ready, branch_taken,
    output fw_en_q, hazard_stall, id_ex_bubble, flush, freeze, mem_err,
           stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// rtl/hazard_controller_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW stall/bubble, branch flush and memory-wait freeze sequencer
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_controller_if.slave hz
);
  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d, wait_inc;
  logic            fw_en_q, fw_en_d;
  logic            mem_err_q, mem_err_d;
  logic            hz1, hz2, hm1, hm2, raw;
  logic            freeze, flush, stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  always_comb begin
    hz1 = hz.id_valid & reg_match(hz.EX_WB_EN, hz.src1, hz.EX_Dest);
    hz2 = hz.id_valid & hz.two_src & reg_match(hz.EX_WB_EN, hz.src2, hz.EX_Dest);
    hm1 = hz.id_valid & reg_match(hz.MEM_WB_EN, hz.src1, hz.MEM_Dest);
    hm2 = hz.id_valid & hz.two_src & reg_match(hz.MEM_WB_EN, hz.src2, hz.MEM_Dest);
    // With forwarding only a load in EX cannot be bypassed in time.
    raw = fw_en_q ? ((hz1 | hz2) & hz.EX_MEM_R_EN) : (hz1 | hz2 | hm1 | hm2);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    freeze    = 1'b0;
    wait_inc  = wait_q + TO_W'(1);
    case (state_q)
      RUN: begin
        freeze = hz.mem_req & ~hz.mem_ready;
        if (freeze) begin
          wait_d = TO_W'(1);
          if (TO_W'(1) >= TIMEOUT_V) mem_err_d = 1'b1;
          else                       state_d   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          wait_d = wait_inc;
          // Give up on the access: flag it and let the pipe move again.
          if (wait_inc >= TIMEOUT_V) begin
            mem_err_d = 1'b1;
            state_d   = RUN;
          end
        end
      end
    endcase
  end

  always_comb begin
    flush   = hz.branch_taken & ~freeze;
    stall   = raw & ~freeze & ~flush;
    fw_en_d = fw_en_q;
    if (state_q == RUN && !freeze && !flush && !raw) fw_en_d = hz.FW_EN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      fw_en_q   <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fw_en_q   <= fw_en_d;
      mem_err_q <= mem_err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk), .rst_ni(rst), .inc_i(stall), .count_o(stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk), .rst_ni(rst), .inc_i(flush), .count_o(flush_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i(clk), .rst_ni(rst), .inc_i(freeze), .count_o(freeze_cnt)
  );

  assign hz.fw_en_q      = fw_en_q;
  assign hz.hazard_stall = stall;
  assign hz.id_ex_bubble = stall;
  assign hz.flush        = flush;
  assign hz.freeze       = freeze;
  assign hz.mem_err      = mem_err_q;
  assign hz.stall_cnt    = stall_cnt;
  assign hz.flush_cnt    = flush_cnt;
  assign hz.freeze_cnt   = freeze_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CNT_W)) hif ();

  hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .hz(hif)
  );

  typedef struct {
    logic       rst, fw_en, id_valid, two_src, ex_wb, ex_ld, mem_wb, mem_req, mem_ready, br;
    logic [3:0] src1, src2, ex_dest, mem_dest;
  } stim_t;

  typedef struct {
    logic stall, flush, freeze, fw, err;
    int   sc, fc, zc;
  } exp_t;

  exp_t  exp_q[$];
  stim_t st;

  bit m_wait, m_fw, m_err;
  int m_cycles, m_sc, m_fc, m_zc;
  int checks = 0, passed = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic int sat_inc(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_fw = 0; m_err = 0;
    m_cycles = 0; m_sc = 0; m_fc = 0; m_zc = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of stimulus, queue what the pipe should see, then advance the model.
  task automatic step();
    exp_t e;
    bit hz1, hz2, hm1, hm2, raw, frz, fl, stl;
    rst              = st.rst;
    hif.FW_EN        = st.fw_en;
    hif.id_valid     = st.id_valid;
    hif.src1         = st.src1;
    hif.src2         = st.src2;
    hif.two_src      = st.two_src;
    hif.EX_Dest      = st.ex_dest;
    hif.EX_WB_EN     = st.ex_wb;
    hif.EX_MEM_R_EN  = st.ex_ld;
    hif.MEM_Dest     = st.mem_dest;
    hif.MEM_WB_EN    = st.mem_wb;
    hif.mem_req      = st.mem_req;
    hif.mem_ready    = st.mem_ready;
    hif.branch_taken = st.br;
    if (!st.rst) model_reset();
    hz1 = st.id_valid && st.ex_wb && st.src1 == st.ex_dest;
    hz2 = st.id_valid && st.two_src && st.ex_wb && st.src2 == st.ex_dest;
    hm1 = st.id_valid && st.mem_wb && st.src1 == st.mem_dest;
    hm2 = st.id_valid && st.two_src && st.mem_wb && st.src2 == st.mem_dest;
    raw = m_fw ? ((hz1 || hz2) && st.ex_ld) : (hz1 || hz2 || hm1 || hm2);
    frz = !st.mem_ready && (m_wait || st.mem_req);
    fl  = st.br && !frz;
    stl = raw && !frz && !fl;
    e.stall = stl; e.flush = fl; e.freeze = frz; e.fw = m_fw; e.err = m_err;
    e.sc = m_sc; e.fc = m_fc; e.zc = m_zc;
    exp_q.push_back(e);
    if (st.rst) begin
      if (!m_wait && !frz && !fl && !raw) m_fw = st.fw_en;
      m_sc = sat_inc(m_sc, stl);
      m_fc = sat_inc(m_fc, fl);
      m_zc = sat_inc(m_zc, frz);
      if (frz) begin
        m_cycles = m_wait ? m_cycles + 1 : 1;
        m_wait   = 1;
        if (m_cycles >= TIMEOUT) begin
          m_err  = 1;
          m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input logic fw);
    for (int i = 0; i < n; i++) begin
      st = idle(); st.fw_en = fw; step();
    end
  endtask

  task automatic load_use(input logic fw, input logic ld, input logic br);
    st = idle(); st.fw_en = fw; st.id_valid = 1; st.src1 = 4'd3; st.src2 = 4'd9;
    st.ex_dest = 4'd3; st.ex_wb = 1; st.ex_ld = ld; st.br = br; step();
  endtask

  task automatic mem_cycle(input logic fw, input logic ready, input logic br);
    st = idle(); st.fw_en = fw; st.mem_req = 1; st.mem_ready = ready; st.br = br; step();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hazard_stall", 32'(hif.hazard_stall), 32'(e.stall));
      chk("id_ex_bubble", 32'(hif.id_ex_bubble), 32'(e.stall));
      chk("flush",        32'(hif.flush),        32'(e.flush));
      chk("freeze",       32'(hif.freeze),       32'(e.freeze));
      chk("fw_en_q",      32'(hif.fw_en_q),      32'(e.fw));
      chk("mem_err",      32'(hif.mem_err),      32'(e.err));
      chk("stall_cnt",    32'(hif.stall_cnt),    32'(e.sc));
      chk("flush_cnt",    32'(hif.flush_cnt),    32'(e.fc));
      chk("freeze_cnt",   32'(hif.freeze_cnt),   32'(e.zc));
    end
  end

  initial begin
    int guard;
    model_reset();
    st = idle(); st.rst = 0;
    rst = 0;
    @(posedge clk);
    #1;
    st = idle(); st.rst = 0; step();
    st = idle(); st.rst = 0; step();
    idle_steps(1, 1'b1);
    idle_steps(1, 1'b1);

    load_use(1'b1, 1'b1, 1'b0);
    load_use(1'b1, 1'b0, 1'b0);
    idle_steps(2, 1'b0);

    st = idle(); st.id_valid = 1; st.src1 = 4'd7; st.src2 = 4'd5; st.two_src = 1;
    st.mem_dest = 4'd5; st.mem_wb = 1; step();
    st.two_src = 0; step();
    st = idle(); st.id_valid = 1; st.ex_dest = 4'd0; st.ex_wb = 1; step();

    repeat (3) mem_cycle(1'b0, 1'b0, 1'b0);
    mem_cycle(1'b0, 1'b1, 1'b0);
    idle_steps(1, 1'b0);

    repeat (4) mem_cycle(1'b0, 1'b0, 1'b0);
    idle_steps(3, 1'b0);

    idle_steps(1, 1'b1);
    load_use(1'b1, 1'b1, 1'b1);
    mem_cycle(1'b1, 1'b0, 1'b1);
    mem_cycle(1'b1, 1'b1, 1'b1);
    idle_steps(1, 1'b1);

    load_use(1'b0, 1'b1, 1'b0);
    load_use(1'b0, 1'b1, 1'b0);
    idle_steps(2, 1'b0);

    repeat (2) mem_cycle(1'b0, 1'b0, 1'b0);
    st = idle(); st.rst = 0; step();
    idle_steps(1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      st.rst       = ($urandom_range(0, 59) != 0);
      st.fw_en     = ($urandom_range(0, 3) != 0);
      st.id_valid  = ($urandom_range(0, 4) != 0);
      st.src1      = 4'($urandom_range(0, 3));
      st.src2      = 4'($urandom_range(0, 3));
      st.two_src   = 1'($urandom_range(0, 1));
      st.ex_dest   = 4'($urandom_range(0, 3));
      st.ex_wb     = 1'($urandom_range(0, 1));
      st.ex_ld     = 1'($urandom_range(0, 1));
      st.mem_dest  = 4'($urandom_range(0, 3));
      st.mem_wb    = 1'($urandom_range(0, 1));
      st.mem_req   = ($urandom_range(0, 2) == 0);
      st.mem_ready = ($urandom_range(0, 3) != 0);
      st.br        = ($urandom_range(0, 5) == 0);
      step();
    end
    idle_steps(2, 1'b0);

    @(negedge clk);
    #1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
